alarm_game_ctrl: RTL

ALARM_GAME_CTRL -- requirements
Module: alarm_game_ctrl

---
 rtl/alarm_pkg.sv | 42 ++++
 rtl/alarm_lfsr_pick.sv | 46 ++++
 rtl/alarm_game_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared state codes, width limits and LFSR tap table for the alarm game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RING   = 3'd2,
    ST_GAME   = 3'd3,
    ST_SNOOZE = 3'd4
  } state_e;

  localparam int CNT_W      = 4;   // round_cnt / snooze_left width
  localparam int ROUNDS_MIN = 1;
  localparam int ROUNDS_MAX = 15;
  localparam int NUM_SW_MIN = 2;
  localparam int NUM_SW_MAX = 32;

  // Maximal-length feedback taps; bit (t-1) set for each tap t.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_00B8;  // 8-bit
    endcase
  endfunction

endpackage

// File: rtl/alarm_lfsr_pick.sv
// Free-running Fibonacci LFSR plus reduction of its low bits to a switch index != prev_idx.
// Latency: LFSR advances every cycle; pick_idx is combinational from the current LFSR value.
// Backpressure: none; the consumer samples pick_idx whenever it needs a draw.
module alarm_lfsr_pick
  import alarm_pkg::*;
#(
  parameter int                LFSR_W = 8,
  parameter int                NUM_SW = 10,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(8'hA5),
  localparam int               IDX_W  = $clog2(NUM_SW)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] prev_idx,
  output logic [IDX_W-1:0] pick_idx
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [IDX_W:0]    NSW  = (IDX_W+1)'(NUM_SW);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [IDX_W:0]    raw_w, red_w, inc_w;

  // Shift left with XOR feedback; a zero state is impossible from a nonzero seed, guarded anyway.
  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    if (lfsr_d == '0) lfsr_d = SEED;
  end

  // LFSR register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  // Fold the low bits into 0..NUM_SW-1, then step past the previous index so draws never repeat.
  always_comb begin
    raw_w = {1'b0, lfsr_q[IDX_W-1:0]};
    red_w = (raw_w >= NSW) ? raw_w - NSW : raw_w;
    inc_w = red_w + (IDX_W+1)'(1);
    if (red_w[IDX_W-1:0] != prev_idx) pick_idx = red_w[IDX_W-1:0];
    else if (inc_w == NSW)            pick_idx = '0;
    else                              pick_idx = inc_w[IDX_W-1:0];
  end

endmodule

// File: rtl/alarm_game_ctrl.sv
// Alarm clock controller: arm, ring, snooze, and a switch-matching game that dismisses the alarm.
// Latency: all outputs registered; state changes one clk edge after the causing input.
// Backpressure: none; tick/push_m/snooze are single-cycle pulses sampled every clock.
module alarm_game_ctrl
  import alarm_pkg::*;
#(
  parameter int                TIME_W       = 16,
  parameter int                NUM_SW       = 10,
  parameter int                ROUNDS       = 3,
  parameter int                MAX_SNOOZE   = 3,
  parameter int                SNOOZE_TICKS = 300,
  parameter int                GAME_TIMEOUT = 60,
  parameter int                LFSR_W       = 8,
  parameter logic [LFSR_W-1:0] SEED         = LFSR_W'(8'hA5)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm_en,
  input  logic              alarm_set,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic [TIME_W-1:0] current_time,
  input  logic              tick,
  input  logic              push_m,
  input  logic              snooze,
  input  logic [NUM_SW-1:0] sw,
  output logic [2:0]        state,
  output logic              ring,
  output logic [NUM_SW-1:0] target,
  output logic [CNT_W-1:0]  round_cnt,
  output logic [CNT_W-1:0]  snooze_left,
  output logic              done
);

  localparam int              IDX_W = $clog2(NUM_SW);
  localparam int              SNZ_W = $clog2(SNOOZE_TICKS + 1);
  localparam int              GTO_W = $clog2(GAME_TIMEOUT + 1);
  localparam logic [NUM_SW-1:0] ONE = NUM_SW'(1);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] alarm_q;
  logic              eq_q, eq_now;
  logic [CNT_W-1:0]  round_q, round_d, round_inc;
  logic [CNT_W-1:0]  snooze_q, snooze_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [GTO_W-1:0]  game_cnt_q, game_cnt_d;
  logic              rel_q, rel_d;
  logic [IDX_W-1:0]  idx_q, idx_d, pick_idx;
  logic [NUM_SW-1:0] target_q, target_d;
  logic              ring_q, ring_d;
  logic              done_q, done_d;

  alarm_lfsr_pick #(
    .LFSR_W (LFSR_W),
    .NUM_SW (NUM_SW),
    .SEED   (SEED)
  ) u_pick (
    .clk      (clk),
    .resetn   (resetn),
    .prev_idx (idx_q),
    .pick_idx (pick_idx)
  );

  assign eq_now    = (current_time == alarm_q);
  assign round_inc = round_q + CNT_W'(1);

  // Alarm register and equality history; the history makes the trigger edge-sensitive.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alarm_q <= '0;
      eq_q    <= 1'b0;
    end else begin
      if (alarm_set) alarm_q <= alarm_time;
      eq_q <= eq_now;
    end
  end

  // Next-state and output decode; arm_en low overrides every other event.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    snooze_d   = snooze_q;
    snz_cnt_d  = snz_cnt_q;
    game_cnt_d = game_cnt_q;
    rel_d      = rel_q;
    idx_d      = idx_q;
    target_d   = target_q;
    done_d     = 1'b0;
    if (!arm_en) begin
      state_d  = ST_IDLE;
      target_d = '0;
      rel_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (eq_now && !eq_q) begin
            state_d  = ST_RING;
            snooze_d = CNT_W'(MAX_SNOOZE);
          end
        end
        ST_RING: begin
          if (push_m) begin
            state_d    = ST_GAME;
            round_d    = '0;
            game_cnt_d = '0;
            rel_d      = 1'b0;
            idx_d      = pick_idx;
            target_d   = ONE << pick_idx;
          end else if (snooze && (snooze_q != '0)) begin
            state_d   = ST_SNOOZE;
            snooze_d  = snooze_q - CNT_W'(1);
            snz_cnt_d = '0;
          end
        end
        ST_SNOOZE: begin
          if (tick) begin
            if (snz_cnt_q == SNZ_W'(SNOOZE_TICKS - 1)) begin
              state_d   = ST_RING;
              snz_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + SNZ_W'(1);
            end
          end
        end
        ST_GAME: begin
          // Switches are judged only after they have been seen all-off since the last judgement.
          if (rel_q && (sw != '0)) begin
            rel_d = 1'b0;
            if (sw == target_q) begin
              round_d = round_inc;
              if (round_inc == CNT_W'(ROUNDS)) begin
                done_d   = 1'b1;
                target_d = '0;
                state_d  = ST_ARMED;
              end else begin
                idx_d    = pick_idx;
                target_d = ONE << pick_idx;
              end
            end else begin
              round_d  = '0;
              idx_d    = pick_idx;
              target_d = ONE << pick_idx;
            end
          end else if (!rel_q && (sw == '0)) begin
            rel_d = 1'b1;
          end
          // Timeout only applies if this cycle did not finish the game.
          if ((state_d == ST_GAME) && tick) begin
            if (game_cnt_q == GTO_W'(GAME_TIMEOUT - 1)) begin
              state_d    = ST_RING;
              round_d    = '0;
              target_d   = '0;
              rel_d      = 1'b0;
              game_cnt_d = '0;
            end else begin
              game_cnt_d = game_cnt_q + GTO_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ring_d = (state_d == ST_RING) || (state_d == ST_GAME);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      round_q    <= '0;
      snooze_q   <= '0;
      snz_cnt_q  <= '0;
      game_cnt_q <= '0;
      rel_q      <= 1'b0;
      idx_q      <= '0;
      target_q   <= '0;
      ring_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      snooze_q   <= snooze_d;
      snz_cnt_q  <= snz_cnt_d;
      game_cnt_q <= game_cnt_d;
      rel_q      <= rel_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      ring_q     <= ring_d;
      done_q     <= done_d;
    end
  end

  assign state       = state_q;
  assign ring        = ring_q;
  assign target      = target_q;
  assign round_cnt   = round_q;
  assign snooze_left = snooze_q;
  assign done        = done_q;

endmodule
